// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
//
// Drives the load enables and bubble (flush) controls of the PC and the IF/ID, ID/EX, EX/MEM
// and MEM/WB registers. It resolves three kinds of hazard:
// - load-use hazards, with a single bubble;
// - taken-branch flushes;
// - variable-latency data-memory accesses, through a req/ack handshake with a timeout.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   ifid_rs1_i/_rs2_i       source registers of the ID instruction
//   ifid_use_rs1_i/_rs2_i   ID instruction actually reads rs1 / rs2
//   idex_memread_i          EX instruction is a load
//   idex_rd_i               destination register of the EX instruction
//   ex_branch_taken_i       branch in EX resolved taken
//   exmem_mem_op_i          EX/MEM holds a load or store
//   mem_ack_i               data memory completes the access this cycle
//   mem_req_o               data-memory request
//   *_we_o, *_flush_o       pipeline-register load enables / bubble inserts
//   mem_fault_o             sticky memory-timeout fault
//   stall_cycles_o          saturating count of cycles with pc_we_o = 0
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [REG_AW-1:0] ifid_rs1_i,
  input  logic [REG_AW-1:0] ifid_rs2_i,
  input  logic              ifid_use_rs1_i,
  input  logic              ifid_use_rs2_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic              ex_branch_taken_i,
  input  logic              exmem_mem_op_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic              pc_we_o,
  output logic              ifid_we_o,
  output logic              idex_we_o,
  output logic              exmem_we_o,
  output logic              memwb_we_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic              memwb_flush_o,
  output logic              mem_fault_o,
  output logic [15:0]       stall_cycles_o
);

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFault   = 2'd2
  } state_e;

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic        mem_fault_q;
  logic [15:0] stall_q;

  logic freeze;
  logic load_use;

  always_comb begin
    load_use = idex_memread_i && (idex_rd_i != '0) &&
               ((ifid_use_rs1_i && (ifid_rs1_i == idex_rd_i)) ||
                (ifid_use_rs2_i && (ifid_rs2_i == idex_rd_i)));
  end

  // Enables and flushes are purely combinational; priority is
  // fault > memory freeze > taken branch > load-use.
  always_comb begin
    mem_req_o     = 1'b0;
    freeze        = 1'b0;
    pc_we_o       = 1'b1;
    ifid_we_o     = 1'b1;
    idex_we_o     = 1'b1;
    exmem_we_o    = 1'b1;
    memwb_we_o    = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    memwb_flush_o = 1'b0;
    if (reset_i || (state_q == StFault)) begin
      pc_we_o    = 1'b0;
      ifid_we_o  = 1'b0;
      idex_we_o  = 1'b0;
      exmem_we_o = 1'b0;
      memwb_we_o = 1'b0;
    end else begin
      mem_req_o = exmem_mem_op_i;
      freeze    = exmem_mem_op_i && !mem_ack_i;
      if (freeze) begin
        // Hold everything upstream of MEM and push a bubble into WB. A branch in EX is
        // held by the frozen ID/EX and acts in the release cycle.
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        idex_we_o     = 1'b0;
        exmem_we_o    = 1'b0;
        memwb_flush_o = 1'b1;
      end else if (ex_branch_taken_i) begin
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
      end else if (load_use) begin
        pc_we_o      = 1'b0;
        ifid_we_o    = 1'b0;
        idex_flush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      mem_fault_q <= 1'b0;
      stall_q     <= 16'd0;
    end else begin
      if (!pc_we_o && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      case (state_q)
        StRun: begin
          if (freeze) begin
            state_q    <= StMemWait;
            wait_cnt_q <= 8'd1;
          end
        end
        StMemWait: begin
          if (mem_ack_i) begin
            state_q    <= StRun;
            wait_cnt_q <= 8'd0;
          end else if (wait_cnt_q < TimeoutCnt) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end else begin
            state_q     <= StFault;
            mem_fault_q <= 1'b1;
          end
        end
        StFault: begin
          state_q <= StFault;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign mem_fault_o    = mem_fault_q;
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TShort = 4;

  logic       clk;
  logic       rst;
  logic [3:0] rs1, rs2, rd;
  logic       u1, u2, mr, br, op, ack;

  logic        req_a, pcwe_a, ifwe_a, idwe_a, exwe_a, mwwe_a, iffl_a, idfl_a, mwfl_a, fault_a;
  logic [15:0] stall_a;
  logic        req_b, pcwe_b, ifwe_b, idwe_b, exwe_b, mwwe_b, iffl_b, idfl_b, mwfl_b, fault_b;
  logic [15:0] stall_b;
  logic [8:0]  out_a, out_b;

  // Output vector: {req, pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_fl, idex_fl, memwb_fl}
  assign out_a = {req_a, pcwe_a, ifwe_a, idwe_a, exwe_a, mwwe_a, iffl_a, idfl_a, mwfl_a};
  assign out_b = {req_b, pcwe_b, ifwe_b, idwe_b, exwe_b, mwwe_b, iffl_b, idfl_b, mwfl_b};

  localparam logic [8:0] OIdle   = 9'h0F8;
  localparam logic [8:0] OBranch = 9'h0FE;
  localparam logic [8:0] OLdUse  = 9'h03A;
  localparam logic [8:0] OFreeze = 9'h109;
  localparam logic [8:0] OZero   = 9'h000;

  pipeline_hazard_ctrl #(.REG_AW(4), .MEM_TIMEOUT(TShort)) dut_a (
    .clk_i(clk), .reset_i(rst), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
    .ifid_use_rs1_i(u1), .ifid_use_rs2_i(u2), .idex_memread_i(mr), .idex_rd_i(rd),
    .ex_branch_taken_i(br), .exmem_mem_op_i(op), .mem_ack_i(ack), .mem_req_o(req_a),
    .pc_we_o(pcwe_a), .ifid_we_o(ifwe_a), .idex_we_o(idwe_a), .exmem_we_o(exwe_a),
    .memwb_we_o(mwwe_a), .ifid_flush_o(iffl_a), .idex_flush_o(idfl_a),
    .memwb_flush_o(mwfl_a), .mem_fault_o(fault_a), .stall_cycles_o(stall_a)
  );

  pipeline_hazard_ctrl #(.REG_AW(4)) dut_b (
    .clk_i(clk), .reset_i(rst), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
    .ifid_use_rs1_i(u1), .ifid_use_rs2_i(u2), .idex_memread_i(mr), .idex_rd_i(rd),
    .ex_branch_taken_i(br), .exmem_mem_op_i(op), .mem_ack_i(ack), .mem_req_o(req_b),
    .pc_we_o(pcwe_b), .ifid_we_o(ifwe_b), .idex_we_o(idwe_b), .exmem_we_o(exwe_b),
    .memwb_we_o(mwwe_b), .ifid_flush_o(iffl_b), .idex_flush_o(idfl_b),
    .memwb_flush_o(mwfl_b), .mem_fault_o(fault_b), .stall_cycles_o(stall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
    u1 = 1'b0; u2 = 1'b0; mr = 1'b0; br = 1'b0; op = 1'b0; ack = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    chk("reset_outputs", 32'(out_a), 32'(OZero));
    tick();
    rst = 1'b0;
    chk("reset_fault", 32'(fault_a), 0);
    chk("reset_stall", 32'(stall_a), 0);
  endtask

  // Reference model: tracks how many consecutive cycles the current access has gone
  // unanswered, whether a fault has latched, and the stall count.
  bit m_fault;
  int m_pend;
  int m_stall;

  function automatic logic [8:0] model_out();
    logic lu;
    if (rst || m_fault) return OZero;
    if (op && !ack) return OFreeze;
    lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    return (br ? OBranch : (lu ? OLdUse : OIdle)) | {op, 8'h00};
  endfunction

  task automatic model_update(input logic [8:0] e);
    if (rst) begin
      m_fault = 0; m_pend = 0; m_stall = 0;
    end else begin
      if (!e[7] && m_stall < 65535) m_stall++;
      if (!m_fault) begin
        if (m_pend == 0) begin
          if (op && !ack) m_pend = 1;
        end else if (ack) begin
          m_pend = 0;
        end else if (m_pend == int'(TShort)) begin
          m_fault = 1;
        end else begin
          m_pend++;
        end
      end
    end
  endtask

  typedef struct {
    logic [3:0] rs1, rs2;
    logic       u1, u2, mr;
    logic [3:0] rd;
    logic       br, op, ack;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [8:0] e;
    int nstall;

    vecs[0]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, OIdle};
    vecs[1]  = '{4'd0, 4'd3, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, OLdUse};
    vecs[2]  = '{4'd5, 4'd0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, OLdUse};
    vecs[3]  = '{4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, OIdle};
    vecs[4]  = '{4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, OIdle};
    vecs[5]  = '{4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, OIdle};
    vecs[6]  = '{4'd0, 4'd3, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, OBranch};
    vecs[7]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, OBranch};
    vecs[8]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 9'h1F8};
    vecs[9]  = '{4'd7, 4'd0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1, 9'h13A};
    vecs[10] = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 9'h1FE};
    vecs[11] = '{4'd2, 4'd4, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, OIdle};

    idle();
    tick();

    // Single-cycle combinational patterns from RUN.
    do_reset();
    nstall = 0;
    for (int i = 0; i < 12; i++) begin
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; u1 = vecs[i].u1; u2 = vecs[i].u2;
      mr = vecs[i].mr; rd = vecs[i].rd; br = vecs[i].br; op = vecs[i].op; ack = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d", i), 32'(out_a), 32'(vecs[i].exp));
      tick();
      if (!vecs[i].exp[7]) nstall++;
      if (i == 1) chk("loaduse_stall_1", 32'(stall_a), 1);
    end
    chk("table_stall", 32'(stall_a), 32'(nstall));

    // Access with 3 wait cycles, branch held until the release cycle.
    do_reset();
    op = 1'b1; br = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("freeze%0d", k), 32'(out_a), 32'(OFreeze));
      tick();
    end
    ack = 1'b1;
    #1;
    chk("release", 32'(out_a), 32'(9'h1FE));
    tick();
    chk("wait3_stall", 32'(stall_a), 3);
    idle();
    #1;
    chk("after_release", 32'(out_a), 32'(OIdle));
    tick();

    // Timeout: short-timeout instance faults after 1+4 cycles, default one after 256.
    do_reset();
    op = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("to_freeze%0d", k), 32'(out_a), 32'(OFreeze));
      tick();
    end
    #1;
    chk("fault_out", 32'(out_a), 32'(OZero));
    chk("fault_flag", 32'(fault_a), 1);
    chk("fault_stall5", 32'(stall_a), 5);
    chk("b_still_wait", 32'(fault_b), 0);
    repeat (3) tick();
    #1;
    chk("fault_hold_out", 32'(out_a), 32'(OZero));
    chk("fault_hold_stall", 32'(stall_a), 8);
    repeat (247) tick();
    #1;
    chk("b_last_wait_out", 32'(out_b), 32'(OFreeze));
    chk("b_last_wait_flag", 32'(fault_b), 0);
    tick();
    #1;
    chk("b_fault_flag", 32'(fault_b), 1);
    chk("b_fault_out", 32'(out_b), 32'(OZero));
    do_reset();
    chk("b_reset_fault", 32'(fault_b), 0);
    chk("b_reset_stall", 32'(stall_b), 0);

    // Reset in the middle of MEM_WAIT (wait_cnt = 2).
    op = 1'b1;
    #1; tick();
    #1; tick();
    do_reset();
    mr = 1'b1; rd = 4'd0; rs1 = 4'd0; u1 = 1'b1;
    #1;
    chk("rd0_no_stall_out", 32'(out_a), 32'(OIdle));
    tick();
    chk("rd0_no_stall", 32'(stall_a), 0);
    idle();
    op = 1'b1;
    repeat (4) begin #1; tick(); end
    #1;
    chk("post_rst_no_fault", 32'(fault_a), 0);
    tick();
    chk("post_rst_fault", 32'(fault_a), 1);

    // Stall counter saturation.
    do_reset();
    mr = 1'b1; rd = 4'd6; rs2 = 4'd6; u2 = 1'b1;
    repeat (65534) tick();
    chk("stall_fffe", 32'(stall_a), 32'h0000_FFFE);
    repeat (6) tick();
    chk("stall_sat", 32'(stall_a), 32'h0000_FFFF);
    repeat (3) tick();
    chk("stall_sat_hold", 32'(stall_a), 32'h0000_FFFF);

    // Randomised run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 0) || ($urandom_range(39) == 0);
      rs1 = 4'($urandom_range(3)); rs2 = 4'($urandom_range(3)); rd = 4'($urandom_range(3));
      u1 = 1'($urandom); u2 = 1'($urandom); mr = 1'($urandom);
      br = ($urandom_range(3) == 0);
      op = 1'($urandom);
      ack = ($urandom_range(2) == 0);
      #1;
      e = model_out();
      if (i > 0) begin
        chk("rnd_fault", 32'(fault_a), 32'(m_fault));
        chk("rnd_stall", 32'(stall_a), 32'(m_stall));
      end
      chk("rnd_out", 32'(out_a), 32'(e));
      model_update(e);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 16-bit five-stage pipeline. It drives the write-enable and bubble (flush) inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch flushes and variable-latency data-memory accesses through a req/ack handshake with a timeout. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_AW, 4: register-address width.
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before fault; range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- ifid_rs1, ifid_rs2  input  REG_AW  source registers of the instruction in ID.
- ifid_use_rs1, ifid_use_rs2  input  1  the ID instruction actually reads rs1 / rs2.
- idex_memread  input  1  the instruction in EX is a load.
- idex_rd  input  REG_AW  destination register of the instruction in EX.
- ex_branch_taken  input  1  the branch in EX resolved taken.
- exmem_mem_op  input  1  EX/MEM holds a load or store.
- mem_ack  input  1  data memory completes the current access this cycle.
- mem_req  output  1  data-memory access request.
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  output  1 each  register load enables.
- ifid_flush, idex_flush, memwb_flush  output  1 each  load a bubble (all control bits 0) instead of data.
- mem_fault  output  1  sticky memory-timeout fault.
- stall_cycles  output  16  saturating count of cycles with pc_we=0.

## Operation
- States: RUN, MEM_WAIT, FAULT. Reset state: RUN. Internal wait_cnt is 8 bits.
- Enables and flushes are combinational from the current state and the inputs. State, wait_cnt, mem_fault and stall_cycles are registered.
- While reset=1, all *_we, *_flush and mem_req are 0. State becomes RUN, wait_cnt=0, mem_fault=0, stall_cycles=0. A reset in any state, including mid-MEM_WAIT or FAULT, aborts to RUN.
- Default (no hazard): all *_we=1, all flushes=0.
- mem_req = exmem_mem_op while the state is RUN or MEM_WAIT. mem_req=0 in FAULT.
- The memory freeze condition is mem_req=1 and mem_ack=0. When it holds:
  - pc_we, ifid_we, idex_we and exmem_we are 0.
  - memwb_we=1 and memwb_flush=1, so WB receives a bubble.
- Memory state transitions:
  - RUN with freeze goes to MEM_WAIT and sets wait_cnt=1.
  - RUN with exmem_mem_op=1 and mem_ack=1 is a zero-wait access: no stall, stay in RUN.
  - MEM_WAIT with mem_ack=1 goes to RUN. Enables follow the non-memory rules in that same cycle.
  - MEM_WAIT with mem_ack=0 and wait_cnt<MEM_TIMEOUT stays in MEM_WAIT and increments wait_cnt.
  - MEM_WAIT with mem_ack=0 and wait_cnt==MEM_TIMEOUT goes to FAULT and sets mem_fault=1.
- FAULT: all *_we=0, all flushes=0, mem_req=0. Left only by reset.
- Taken branch (ex_branch_taken=1, no freeze): pc_we=1, ifid_flush=1, idex_flush=1. All other enables stay 1.
- Load-use hazard:
  - Condition: idex_memread=1, idex_rd≠0, and either (ifid_use_rs1 and ifid_rs1==idex_rd) or (ifid_use_rs2 and ifid_rs2==idex_rd).
  - Response (no freeze, no branch): pc_we=0, ifid_we=0, idex_flush=1 with idex_we=1. Exactly one bubble per occurrence.
- Priority: FAULT > memory freeze > taken branch > load-use.
  - A branch together with a load-use hazard takes the branch response only.
  - A branch that arrives during a freeze is held, because ID/EX is frozen. It takes effect in the release cycle.
- stall_cycles increments in every non-reset cycle with pc_we=0, including FAULT. It saturates at 16'hFFFF.

## Timing
- Enable/flush/mem_req outputs respond in the same cycle as their inputs, with zero latency.
- State, wait_cnt, mem_fault and stall_cycles update on the rising clock edge.
- A memory access with k wait cycles (mem_ack arrives in the (k+1)th cycle of mem_req) gives exactly k frozen cycles and k MEM/WB bubbles.
- mem_req stays high continuously from the first cycle until the ack cycle inclusive.
- FAULT is entered on the edge after the MEM_TIMEOUT-th MEM_WAIT cycle without ack.

## Test plan
- Load-use: idex_memread=1, idex_rd=3, ifid_rs2=3, ifid_use_rs2=1 for 1 cycle → pc_we=0, ifid_we=0, idex_flush=1 in that cycle; stall_cycles goes 0→1.
- Taken branch and load-use in the same cycle → pc_we=1, ifid_flush=1, idex_flush=1, ifid_we=1; stall_cycles unchanged.
- exmem_mem_op=1 with mem_ack on the 4th cycle → 3 freeze cycles, each with memwb_flush=1; mem_req high for 4 cycles; state returns to RUN; stall_cycles=3.
- MEM_TIMEOUT=4, mem_ack never asserted → after 1 RUN freeze cycle plus 4 MEM_WAIT cycles, mem_fault=1, all enables 0, mem_req=0; state holds until reset.
- Reset asserted for 1 cycle during MEM_WAIT (wait_cnt=2) → next cycle RUN, mem_fault=0, stall_cycles=0; a subsequent idex_rd=0 load-use pattern produces no stall.
- Force 65540 stall cycles → stall_cycles reads 16'hFFFF and stays there.
